// File: rtl/tm1638_responder.sv
// rtl/tm1638_responder.sv - TM1638 device-side responder: serial decode, 16x8 display RAM, key read
// Key-read path is built only when TM1638_RESP_KEY_READ_EN is defined.
module tm1638_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_SPI_Stb,
    input  logic        i_SPI_Clk,
    input  logic        i_SPI_Dio,
    output logic        o_SPI_Dio,
    output logic        o_SPI_Dio_Oe,
    input  logic [31:0] i_Keys,
    input  logic [3:0]  i_Ram_Addr,
    output logic [7:0]  o_Ram_Data,
    output logic        o_Wr_Valid,
    output logic [3:0]  o_Wr_Addr,
    output logic [7:0]  o_Wr_Data,
    output logic        o_Display_On,
    output logic [2:0]  o_Brightness,
    output logic        o_Cmd_Error
);
    typedef enum logic [1:0] {S_CMD, S_WRITE, S_IGNORE, S_READ} frame_state_t;

    logic [SYNC_STAGES-1:0] stb_sync, clk_sync, dio_sync;
    logic       stb_s, clk_s, dio_s;
    logic       stb_prev, clk_prev;
    logic       clk_rise, clk_fall, stb_fall, frame_on;
    logic       active;
    frame_state_t state;
    logic [2:0] bit_cnt;
    logic [7:0] shift_q;
    logic [7:0] byte_in;
    logic       fixed_mode;
    logic [3:0] addr;
    logic [7:0] ram [16];
`ifdef TM1638_RESP_KEY_READ_EN
    logic [31:0] snap;
`else
    logic unused_keys;
    assign unused_keys  = ^i_Keys;
    assign o_SPI_Dio    = 1'b0;
    assign o_SPI_Dio_Oe = 1'b0;
`endif

    assign stb_s    = stb_sync[SYNC_STAGES-1];
    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign dio_s    = dio_sync[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_prev;
    assign clk_fall = ~clk_s & clk_prev;
    assign stb_fall = ~stb_s & stb_prev;
    // A frame only counts once a genuine STB fall has been seen since reset.
    assign frame_on = active | stb_fall;
    assign byte_in  = {dio_s, shift_q[7:1]};
    assign o_Ram_Data = ram[i_Ram_Addr];

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            stb_sync <= '0;
            clk_sync <= '1;
            dio_sync <= '0;
            stb_prev <= 1'b0;
            clk_prev <= 1'b1;
        end else begin
            stb_sync <= {stb_sync[SYNC_STAGES-2:0], i_SPI_Stb};
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], i_SPI_Clk};
            dio_sync <= {dio_sync[SYNC_STAGES-2:0], i_SPI_Dio};
            stb_prev <= stb_s;
            clk_prev <= clk_s;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            active       <= 1'b0;
            state        <= S_CMD;
            bit_cnt      <= 3'd0;
            shift_q      <= 8'h00;
            fixed_mode   <= 1'b0;
            addr         <= 4'd0;
            o_Wr_Valid   <= 1'b0;
            o_Wr_Addr    <= 4'd0;
            o_Wr_Data    <= 8'h00;
            o_Display_On <= 1'b0;
            o_Brightness <= 3'd0;
            o_Cmd_Error  <= 1'b0;
            for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
`ifdef TM1638_RESP_KEY_READ_EN
            snap         <= 32'h0;
            o_SPI_Dio    <= 1'b0;
            o_SPI_Dio_Oe <= 1'b0;
`endif
        end else begin
            o_Wr_Valid  <= 1'b0;
            o_Cmd_Error <= 1'b0;
            if (stb_s) begin
                active  <= 1'b0;
                state   <= S_CMD;
                bit_cnt <= 3'd0;
                shift_q <= 8'h00;
`ifdef TM1638_RESP_KEY_READ_EN
                o_SPI_Dio    <= 1'b0;
                o_SPI_Dio_Oe <= 1'b0;
`endif
            end else begin
                if (stb_fall) active <= 1'b1;
                if (frame_on && clk_rise) begin
                    shift_q <= byte_in;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        case (state)
                            S_CMD: begin
                                case (byte_in[7:6])
                                    2'b01: begin
                                        fixed_mode <= byte_in[2];
                                        state      <= S_IGNORE;
`ifdef TM1638_RESP_KEY_READ_EN
                                        if (byte_in[1]) begin
                                            state        <= S_READ;
                                            snap         <= i_Keys;
                                            o_SPI_Dio_Oe <= 1'b1;
                                        end
`endif
                                    end
                                    2'b11: begin
                                        addr  <= byte_in[3:0];
                                        state <= S_WRITE;
                                    end
                                    2'b10: begin
                                        o_Display_On <= byte_in[3];
                                        o_Brightness <= byte_in[2:0];
                                        state        <= S_IGNORE;
                                    end
                                    default: begin
                                        o_Cmd_Error <= 1'b1;
                                        state       <= S_IGNORE;
                                    end
                                endcase
                            end
                            S_WRITE: begin
                                ram[addr]  <= byte_in;
                                o_Wr_Valid <= 1'b1;
                                o_Wr_Addr  <= addr;
                                o_Wr_Data  <= byte_in;
                                if (!fixed_mode) addr <= addr + 4'd1;
                            end
                            default: ;
                        endcase
                    end
                end
`ifdef TM1638_RESP_KEY_READ_EN
                // Zero-filling shift leaves DIO low once all 32 key bits are out.
                if (frame_on && clk_fall && state == S_READ) begin
                    o_SPI_Dio <= snap[0];
                    snap      <= {1'b0, snap[31:1]};
                end
`endif
            end
        end
    end
endmodule

// File: doc/tm1638_responder.md
# tm1638_responder

- Synthesizable device-side model of the TM1638 LED/key controller; the receiving end of the STB/CLK/DIO serial link produced by the tm1638 master.
- Oversamples the serial pins on the system clock and decodes data, address and display-control commands into a 16×8 display RAM.
- Serves key-scan reads by driving DIO back.
- Used as a loopback target on the FPGA and as the DUT-side partner in master benches.

## Interface
- SYNC_STAGES, 2: synchronizer flops on STB/CLK/DIO inputs (≥2).
- i_Clk  in  1  system clock, all logic on rising edge.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_SPI_Stb  in  1  frame select, active low, asynchronous to i_Clk.
- i_SPI_Clk  in  1  serial clock; data sampled on its rising edge.
- i_SPI_Dio  in  1  serial data from master, LSB first.
- o_SPI_Dio  out  1  serial data to master (key bytes).
- o_SPI_Dio_Oe  out  1  1 = responder drives DIO.
- i_Keys  in  32  key-scan word; byte 0 = bits 7:0, sent first.
- i_Ram_Addr  in  4  display RAM read address.
- o_Ram_Data  out  8  combinational read of RAM[i_Ram_Addr].
- o_Wr_Valid  out  1  one-cycle pulse per RAM write.
- o_Wr_Addr  out  4  address of that write.
- o_Wr_Data  out  8  data of that write.
- o_Display_On  out  1  display-control bit 3.
- o_Brightness  out  3  display-control bits 2:0.
- o_Cmd_Error  out  1  one-cycle pulse on an undefined command byte.

## Operation
- Inputs pass through SYNC_STAGES flops. Edge detect on synchronized CLK and STB.
- Synchronized STB high clears the bit counter, the byte index and the partial shift register, and deasserts o_SPI_Dio_Oe.
- While STB is low, each synchronized CLK rising edge shifts the synchronized DIO into bit[n], n = 0..7.
- The 8th bit completes a byte.
- The first byte of a frame is the command, decoded by bits 7:6:
  - 01 data command: bit2 = fixed address (1) / auto-increment (0), stored persistently. Bit1 = read keys. Bit3 is ignored.
  - 11 address command: addr ← bits 3:0. Every later byte in the frame is written to RAM[addr]. In auto-increment mode addr then increments, wrapping 15→0; in fixed mode it is unchanged.
  - 10 display control: o_Display_On ← bit3, o_Brightness ← bits 2:0.
  - 00: o_Cmd_Error pulses and the rest of the frame is ignored.
- Bytes after a data command or a display command within the same frame are ignored.
- Read (data command with bit1 = 1):
  - On completion of the command byte, i_Keys is snapshotted and o_SPI_Dio_Oe ← 1.
  - On each later synchronized CLK falling edge, the next snapshot bit is presented, starting with bit 0.
  - After 32 bits, o_SPI_Dio = 0 until STB goes high.
- A partial byte is discarded when STB rises.
- Reset values:
  - o_SPI_Dio = 0, o_SPI_Dio_Oe = 0.
  - o_Wr_Valid = 0, o_Wr_Addr = 0, o_Wr_Data = 0.
  - o_Display_On = 0, o_Brightness = 0, o_Cmd_Error = 0.
  - RAM all 0x00, mode = auto-increment, addr = 0.

## Timing
- Pin-to-event latency is SYNC_STAGES+1 i_Clk cycles.
- The master must hold each CLK high and low phase for ≥ SYNC_STAGES+1 i_Clk cycles, and keep DIO stable around rising CLK for the same time.
- o_Wr_Valid, o_Wr_Addr and o_Wr_Data are valid in the cycle after the 8th-bit rising edge is detected. o_Ram_Data reflects the write from the following cycle.
- o_Cmd_Error and the display-control outputs update in the cycle after the command byte completes.
- Read data changes one cycle after a synchronized CLK falling edge, and is stable for the whole high phase for master sampling.
- Bit 0 appears at the falling edge that ends the command's 8th clock.
- o_SPI_Dio_Oe drops ≤ SYNC_STAGES+1 cycles after STB rises.
- If STB rises and CLK rises in the same synchronized cycle, STB wins and no bit is taken.
- Asynchronous reset mid-frame returns everything to reset values immediately. The next frame must begin with a fresh STB fall.

## Configuration
- TM1638_RESP_KEY_READ_EN defined: key-read path present as described.
- Not defined:
  - Read bit1 is ignored and the command is treated as a write-mode data command.
  - o_SPI_Dio_Oe and o_SPI_Dio are tied to 0.
  - i_Keys is unused.

## Test plan
- Auto-increment write: frame 0x40, then frame 0xC0, 0x3F, 0x06. Required: RAM[0] = 0x3F, RAM[1] = 0x06, exactly 2 o_Wr_Valid pulses with addresses 0 and 1.
- Fixed address: frame 0x44, then frame 0xC5, 0xAA, 0x55. Required: RAM[5] = 0x55, RAM[6] unchanged, both pulses show address 5.
- Wrap-around: frame 0x40, then frame 0xCF, 0x11, 0x22. Required: RAM[15] = 0x11, RAM[0] = 0x22.
- Display control and error:
  - Frame 0x8A: o_Display_On = 1, o_Brightness = 2.
  - Frame 0x00, 0x55: one o_Cmd_Error pulse and no RAM write.
- Key read (macro on): i_Keys = 0x04008001, frame 0x42 followed by 32 clocks.
  - Master must receive 0x01, 0x80, 0x00, 0x04, LSB first.
  - o_SPI_Dio_Oe must fall ≤ 3 cycles after STB rises.
  - With the macro off, o_SPI_Dio_Oe must stay 0.
- Abort: frame 0xC3 followed by 5 bits, then STB high.
  - Required: no write, addr state irrelevant.
  - A following frame 0xC3, 0x7E must write RAM[3] = 0x7E.
  - An asynchronous reset during that frame must leave RAM all zero.
